// File: rtl/rv32i_types.sv
// Shared types and constants for the cache/memory arbiter slice.
//   arb_state_t : arbiter FSM states
//   LINE_W      : cache line width in bits
//   BEAT_W      : memory burst beat width in bits
//   BEATS       : beats per line
//   OFFSET_BITS : line-offset bits cleared from burst addresses
package rv32i_types;

    localparam int unsigned LINE_W      = 32'd256;
    localparam int unsigned BEAT_W      = 32'd64;
    localparam int unsigned BEATS       = LINE_W / BEAT_W;
    localparam int unsigned OFFSET_BITS = 32'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } arb_state_t;

    // Clear the in-line byte offset so memory always sees a line-aligned address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
    endfunction

endpackage

// File: rtl/line_burst_buffer.sv
// Line register plus beat counter for one 4-beat burst.
//   clk, rst_n  : clock, asynchronous active-low reset
//   beat_adv    : a beat was accepted this cycle (pmem_resp inside a burst)
//   capture     : store rdata_beat into the current beat slot (read bursts)
//   rdata_beat  : incoming memory beat
//   wdata_line  : outgoing write-back line
//   wdata_beat  : slice of wdata_line selected by the beat counter
//   line        : assembled read line (holds until the next read overwrites it)
//   last_beat   : the counter points at the final beat of the line
module line_burst_buffer #(
    parameter int unsigned LINE_W = rv32i_types::LINE_W,
    parameter int unsigned BEAT_W = rv32i_types::BEAT_W,
    parameter int unsigned BEATS  = rv32i_types::BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_adv,
    input  logic              capture,
    input  logic [BEAT_W-1:0] rdata_beat,
    input  logic [LINE_W-1:0] wdata_line,
    output logic [BEAT_W-1:0] wdata_beat,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    localparam int unsigned CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]  beat_r;
    logic [LINE_W-1:0] line_r;
    logic              last_beat_s;

    assign last_beat_s = (beat_r == CNT_W'(BEATS - 32'd1));
    assign last_beat   = last_beat_s;
    assign line        = line_r;
    assign wdata_beat  = wdata_line[beat_r * BEAT_W +: BEAT_W];

    // Beat counter: steps once per accepted beat and wraps after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r <= '0;
        end else if (beat_adv) begin
            if (last_beat_s) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + CNT_W'(32'd1);
            end
        end
    end

    // Line buffer: drop each read beat into its slot; cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= '0;
        end else if (capture) begin
            line_r[beat_r * BEAT_W +: BEAT_W] <= rdata_beat;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I-cache and
// D-cache line traffic. One 256-bit line per grant, moved as 4 x 64-bit beats.
//   clk, rst               : clock, asynchronous active-low reset
//   i_read/i_addr          : I-cache line read request (level) and address
//   i_rdata/i_resp         : returned line and one-cycle completion pulse
//   d_read/d_write/d_addr  : D-cache read / write-back request and address
//   d_wdata                : write-back line
//   d_rdata/d_resp         : returned line and one-cycle completion pulse
//   pmem_read/pmem_write   : burst request, held for the whole burst
//   pmem_addr              : line-aligned burst address
//   pmem_wdata             : current write beat
//   pmem_rdata/pmem_resp   : current read beat / per-beat handshake
module cache_mem_arbiter #(
    parameter int unsigned LINE_W = rv32i_types::LINE_W,
    parameter int unsigned BEAT_W = rv32i_types::BEAT_W,
    parameter int unsigned BEATS  = rv32i_types::BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import rv32i_types::*;

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic              last_d_r;
    logic [31:0]       addr_r;
    logic              pmem_read_r;
    logic              pmem_write_r;
    logic              i_resp_r;
    logic              d_resp_r;
    logic              d_req_s;
    logic              burst_s;
    logic              read_burst_s;
    logic              beat_adv_s;
    logic              last_beat_s;
    logic [LINE_W-1:0] line_s;

    assign d_req_s      = d_read | d_write;
    assign read_burst_s = (state_r == I_RD) || (state_r == D_RD);
    assign burst_s      = read_burst_s || (state_r == D_WR);
    assign beat_adv_s   = burst_s & pmem_resp;

    line_burst_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst),
        .beat_adv   (beat_adv_s),
        .capture    (read_burst_s & pmem_resp),
        .rdata_beat (pmem_rdata),
        .wdata_line (d_wdata),
        .wdata_beat (pmem_wdata),
        .line       (line_s),
        .last_beat  (last_beat_s)
    );

    // Next-state decode; on a tie the requester not served last wins, and a
    // write-back beats a read if the D-cache raises both.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s && (!i_read || !last_d_r)) begin
                    if (d_write) begin
                        next_state_s = D_WR;
                    end else begin
                        next_state_s = D_RD;
                    end
                end else if (i_read) begin
                    next_state_s = I_RD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (beat_adv_s && last_beat_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Outputs registered from the state being entered, so they line up with
    // the state itself while staying glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            pmem_read_r  <= (next_state_s == I_RD) || (next_state_s == D_RD);
            pmem_write_r <= (next_state_s == D_WR);
            i_resp_r     <= (state_r == I_RD) && (next_state_s == DONE);
            d_resp_r     <= ((state_r == D_RD) || (state_r == D_WR)) && (next_state_s == DONE);
        end
    end

    // Address latch at grant time; later requester address changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= 32'h0000_0000;
        end else if (state_r == IDLE) begin
            if (next_state_s == I_RD) begin
                addr_r <= line_align(i_addr);
            end else if ((next_state_s == D_RD) || (next_state_s == D_WR)) begin
                addr_r <= line_align(d_addr);
            end
        end
    end

    // Round-robin history: remember whether D was the one just answered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_r <= 1'b0;
        end else if (state_r == DONE) begin
            last_d_r <= d_resp_r;
        end
    end

    assign pmem_read  = pmem_read_r;
    assign pmem_write = pmem_write_r;
    assign pmem_addr  = addr_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;
    assign i_rdata    = line_s;
    assign d_rdata    = line_s;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios, a bench-side
// memory responder, a transaction-level reference model and a per-cycle compare.
module tb_cache_mem_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [31:0]   i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_addr;
    logic [BW-1:0] pmem_wdata;
    logic [BW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    // memory responder controls
    logic [LW-1:0] mem_line;
    bit            stall_q[$];
    int            mem_cnt;

    // reference model state
    int            m_ph;      // 0 idle, 1 in burst, 2 answering
    bit            m_who_d;
    bit            m_wr;
    bit            m_last_d;
    int            m_beats;
    logic [31:0]   m_addr;
    logic [LW-1:0] m_line;
    logic [LW-1:0] m_wline;

    logic [BW-1:0] wlog[$];

    cache_mem_arbiter #(.LINE_W(LW), .BEAT_W(BW), .BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: one beat per burst cycle unless a stall bit says otherwise.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mem_cnt    = 0;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (!rst) begin
                mem_cnt    = 0;
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end else if (pmem_read || pmem_write) begin
                bit go;
                go = (stall_q.size() > 0) ? stall_q.pop_front() : 1'b1;
                pmem_resp  = go;
                pmem_rdata = go ? mem_line[(mem_cnt % 4) * BW +: BW] : 64'hDEAD_BEEF_DEAD_BEEF;
                if (go) mem_cnt++;
            end else begin
                mem_cnt    = 0;
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end
        end
    end

    // Reference model: who owns the port, which beat is next, what line was read.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph     <= 0;
            m_last_d <= 1'b0;
            m_beats  <= 0;
            m_line   <= '0;
            m_addr   <= 32'h0;
            m_who_d  <= 1'b0;
            m_wr     <= 1'b0;
        end else if (m_ph == 0) begin
            m_beats <= 0;
            if ((d_read || d_write) && (!i_read || !m_last_d)) begin
                m_ph    <= 1;
                m_who_d <= 1'b1;
                m_wr    <= d_write;
                m_addr  <= {d_addr[31:5], 5'b00000};
                m_wline <= d_wdata;
            end else if (i_read) begin
                m_ph    <= 1;
                m_who_d <= 1'b0;
                m_wr    <= 1'b0;
                m_addr  <= {i_addr[31:5], 5'b00000};
            end
        end else if (m_ph == 1) begin
            if (pmem_resp) begin
                if (!m_wr) m_line[m_beats * BW +: BW] <= pmem_rdata;
                m_beats <= m_beats + 1;
                if (m_beats == 3) m_ph <= 2;
            end
        end else begin
            m_ph     <= 0;
            m_last_d <= m_who_d;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("pmem_read", pmem_read, (m_ph == 1) && !m_wr);
            check("pmem_write", pmem_write, (m_ph == 1) && m_wr);
            check("i_resp", i_resp, (m_ph == 2) && !m_who_d);
            check("d_resp", d_resp, (m_ph == 2) && m_who_d);
            if (m_ph == 1) check("pmem_addr", pmem_addr, m_addr);
            if (m_ph == 1 && m_wr) check("pmem_wdata", pmem_wdata, m_wline[m_beats * BW +: BW]);
            if (m_ph == 2 && !m_who_d) check("i_rdata", i_rdata, m_line);
            if (m_ph == 2 && m_who_d) check("d_rdata", d_rdata, m_line);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the chosen response; k counts cycles from the request cycle.
    task automatic serve(input bit want_d, output int lat, output logic [31:0] addr1,
                         output logic rd1, output logic wr1, output int wr_cycles,
                         output logic [LW-1:0] rline);
        lat = -1; addr1 = 32'h0; rd1 = 1'b0; wr1 = 1'b0; wr_cycles = 0; rline = '0;
        wlog.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr1 = pmem_addr;
                rd1   = pmem_read;
                wr1   = pmem_write;
            end
            if (pmem_write) wr_cycles++;
            if (pmem_write && pmem_resp) wlog.push_back(pmem_wdata);
            if (want_d ? d_resp : i_resp) begin
                lat   = k;
                rline = want_d ? d_rdata : i_rdata;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no response within 40 cycles", want_d ? "d" : "i");
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            wc;
        logic [31:0]   a1;
        logic          r1;
        logic          w1;
        logic [LW-1:0] rl;
        logic [BW-1:0] exp_beat;

        rst = 1'b0; i_read = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = '0; mem_line = '0;
        #12;
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_addr", pmem_addr, 32'h0);
        check("rst_i_resp", i_resp, 1'b0);
        check("rst_d_resp", d_resp, 1'b0);
        check("rst_rdata", i_rdata, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Ties after reset: D first, then I, then D's new request.
        mem_line = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                    64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
        i_addr = 32'h0000_0100; i_read = 1'b1;
        d_addr = 32'h0000_0200; d_read = 1'b1;
        serve(1'b1, lat, a1, r1, w1, wc, rl);
        check("tie1_lat", lat, 5);
        check("tie1_addr", a1, 32'h0000_0200);
        check("tie1_read", r1, 1'b1);
        d_addr = 32'h0000_0300;
        serve(1'b0, lat, a1, r1, w1, wc, rl);
        i_read = 1'b0;
        check("tie2_lat", lat, 5);
        check("tie2_addr", a1, 32'h0000_0100);
        serve(1'b1, lat, a1, r1, w1, wc, rl);
        d_read = 1'b0;
        check("tie3_lat", lat, 5);
        check("tie3_addr", a1, 32'h0000_0300);

        // I read alone.
        mem_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        i_addr = 32'h0000_1234; i_read = 1'b1;
        serve(1'b0, lat, a1, r1, w1, wc, rl);
        i_read = 1'b0;
        check("iread_lat", lat, 5);
        check("iread_addr", a1, 32'h0000_1220);
        check("iread_line", rl, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // D write-back.
        d_wdata = {64'hDDDD_DDDD_0000_0003, 64'hDDDD_DDDD_0000_0002,
                   64'hDDDD_DDDD_0000_0001, 64'hDDDD_DDDD_0000_0000};
        d_addr = 32'h0000_2000; d_write = 1'b1;
        serve(1'b1, lat, a1, r1, w1, wc, rl);
        d_write = 1'b0;
        check("dwr_lat", lat, 5);
        check("dwr_write", w1, 1'b1);
        check("dwr_read", r1, 1'b0);
        check("dwr_cycles", wc, 4);
        check("dwr_nbeats", wlog.size(), 4);
        for (int j = 0; j < 4; j++) begin
            exp_beat = {48'hDDDD_DDDD_0000, 16'(j)};
            if (j < wlog.size()) check("dwr_beat", wlog[j], exp_beat);
        end

        // Memory stalls: resp pattern 1,0,0,1,1,0,1.
        mem_line = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                    64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        stall_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        i_addr = 32'h0000_3000; i_read = 1'b1;
        serve(1'b0, lat, a1, r1, w1, wc, rl);
        i_read = 1'b0;
        check("stall_lat", lat, 8);
        check("stall_line", rl, {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                                 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000});

        // Reset in the middle of a D read, then a clean I read.
        mem_line = {4{64'h5555_AAAA_5555_AAAA}};
        d_addr = 32'h0000_4000; d_read = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("mid_busy", pmem_read, 1'b1);
        rst = 1'b0; d_read = 1'b0;
        #1;
        check("mrst_pmem_read", pmem_read, 1'b0);
        check("mrst_pmem_write", pmem_write, 1'b0);
        check("mrst_pmem_addr", pmem_addr, 32'h0);
        check("mrst_resp", {i_resp, d_resp}, 2'b00);
        check("mrst_line", d_rdata, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_line = {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                    64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};
        i_addr = 32'h0000_5000; i_read = 1'b1;
        serve(1'b0, lat, a1, r1, w1, wc, rl);
        i_read = 1'b0;
        check("post_rst_lat", lat, 5);
        check("post_rst_line", rl, {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                                    64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666});

        // Illegal d_read and d_write together: write wins.
        d_wdata = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
        d_addr = 32'h0000_6008; d_read = 1'b1; d_write = 1'b1;
        serve(1'b1, lat, a1, r1, w1, wc, rl);
        d_read = 1'b0; d_write = 1'b0;
        check("illegal_write", w1, 1'b1);
        check("illegal_read", r1, 1'b0);
        check("illegal_addr", a1, 32'h0000_6000);
        check("illegal_lat", lat, 5);
        check("illegal_cycles", wc, 4);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
